// File: rtl/frame_ring_buffer_pkg.sv
// frame_ring_buffer_pkg: shared types, role index and FSM state for the frame ring buffer
package frame_ring_buffer_pkg;
    localparam int LOG_MAX_ADDR = 13;
    localparam int WORD_SIZE = 16;
    typedef logic [LOG_MAX_ADDR-1:0] addr_t;
    typedef logic [WORD_SIZE-1:0] data_t;
    typedef logic [1:0] buf_role_t;
    typedef enum logic [1:0] {ST_READY, ST_WAIT_VSYNC, ST_CLEAR} state_t;
    // With three banks numbered 0..2 the remaining index is 3 minus the other two
    function automatic buf_role_t third_idx(buf_role_t a, buf_role_t b);
        return buf_role_t'(2'd3 - a - b);
    endfunction
endpackage

// File: rtl/frame_ring_buffer_tdp_bank.sv
// frame_ring_buffer_tdp_bank: inferred true-dual-port bank, write on A, registered reads on A and B
module frame_ring_buffer_tdp_bank #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH = 4800,
    parameter int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 we_a,
    input  logic [LOG_DEPTH-1:0] addr_a,
    input  logic [WORD_SIZE-1:0] din_a,
    output logic [WORD_SIZE-1:0] dout_a,
    input  logic [LOG_DEPTH-1:0] addr_b,
    output logic [WORD_SIZE-1:0] dout_b
);
    logic [WORD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk_in)
        if (we_a) mem[addr_a] <= din_a;

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            dout_a <= mem[addr_a];
            dout_b <= mem[addr_b];
        end
endmodule

// File: rtl/frame_ring_buffer.sv
// frame_ring_buffer: 2/3-bank frame store rotating back, front and display roles on swap/vsync
module frame_ring_buffer #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH = 4800,
    parameter int NUM_BUFS = 3,
    parameter bit CLEAR_ON_SWAP = 1'b1,
    localparam int LOG_DEPTH = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 swap_in,
    input  logic                 vsync_in,
    input  logic [LOG_DEPTH-1:0] render_addr_r,
    input  logic [LOG_DEPTH-1:0] logic_addr_r,
    input  logic [LOG_DEPTH-1:0] logic_addr_w,
    input  logic [WORD_SIZE-1:0] logic_data_w,
    input  logic                 logic_wr_en,
    output logic                 ready_out,
    output logic                 swap_done_out,
    output logic [1:0]           front_idx_out,
    output logic [WORD_SIZE-1:0] render_data_r,
    output logic [WORD_SIZE-1:0] logic_data_r
);
    import frame_ring_buffer_pkg::*;

    if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
        $error("frame_ring_buffer: NUM_BUFS must be 2 or 3");
    end

    state_t state, state_nx;
    buf_role_t back_idx, front_idx, disp_idx, back_nx, front_nx, disp_nx, disp_vs, front_q, disp_q;
    logic [LOG_DEPTH-1:0] clr_cnt;
    logic clr_last, rotate, swap_ok;
    logic [WORD_SIZE-1:0] dout_a [NUM_BUFS];
    logic [WORD_SIZE-1:0] dout_b [NUM_BUFS];

    assign ready_out = state == ST_READY && !rst_in;
    assign front_idx_out = front_idx;
    assign swap_ok = state == ST_READY && swap_in;
    assign clr_last = clr_cnt == LOG_DEPTH'(DEPTH - 1);

    always_comb begin
        rotate = (swap_ok && NUM_BUFS == 3) || (state == ST_WAIT_VSYNC && vsync_in);
        state_nx = rotate ? (CLEAR_ON_SWAP ? ST_CLEAR : ST_READY)
                 : swap_ok ? ST_WAIT_VSYNC
                 : (state == ST_CLEAR && clr_last) ? ST_READY : state;
        disp_vs = (NUM_BUFS == 3 && vsync_in) ? front_idx : disp_idx;
        front_nx = rotate ? back_idx : front_idx;
        back_nx = !rotate ? back_idx : NUM_BUFS == 2 ? front_idx : third_idx(back_idx, disp_vs);
        disp_nx = NUM_BUFS == 2 ? front_nx : disp_vs;
    end

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            state <= CLEAR_ON_SWAP ? ST_CLEAR : ST_READY;
            back_idx <= 2'd1;
            front_idx <= 2'd0;
            disp_idx <= 2'd0;
            front_q <= 2'd0;
            disp_q <= 2'd0;
            clr_cnt <= '0;
            swap_done_out <= 1'b0;
        end else begin
            state <= state_nx;
            back_idx <= back_nx;
            front_idx <= front_nx;
            disp_idx <= disp_nx;
            front_q <= front_idx;
            disp_q <= disp_idx;
            clr_cnt <= (state == ST_CLEAR && !clr_last) ? clr_cnt + 1'b1 : '0;
            swap_done_out <= rotate;
        end

    // Port A of the back bank carries writes; every other bank's port A serves logic reads
    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_bank
        logic is_back;
        assign is_back = back_idx == buf_role_t'(i);
        frame_ring_buffer_tdp_bank #(
            .WORD_SIZE(WORD_SIZE),
            .DEPTH(DEPTH),
            .LOG_DEPTH(LOG_DEPTH)
        ) u_bank (
            .clk_in(clk_in),
            .rst_in(rst_in),
            .we_a(is_back && (state == ST_CLEAR || (state == ST_READY && logic_wr_en))),
            .addr_a(!is_back ? logic_addr_r : state == ST_CLEAR ? clr_cnt : logic_addr_w),
            .din_a(state == ST_CLEAR ? '0 : logic_data_w),
            .dout_a(dout_a[i]),
            .addr_b(render_addr_r),
            .dout_b(dout_b[i])
        );
    end

    always_comb begin
        render_data_r = '0;
        logic_data_r = '0;
        for (int b = 0; b < NUM_BUFS; b++) begin
            if (disp_q == buf_role_t'(b)) render_data_r = dout_b[b];
            if (front_q == buf_role_t'(b)) logic_data_r = dout_a[b];
        end
    end
endmodule

// File: tb/tb_frame_ring_buffer.sv
// tb_frame_ring_buffer: triple- and double-buffer instances checked against a role/memory model
module tb_frame_ring_buffer;
    localparam int DEPTH = 16;
    localparam int M_READY = 0, M_WAIT = 1, M_CLEAR = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic swap_in = 1'b0, vsync_in = 1'b0, logic_wr_en = 1'b0;
    logic [3:0] render_addr_r = '0, logic_addr_r = '0, logic_addr_w = '0;
    logic [15:0] logic_data_w = '0;
    logic ready3, sd3, ready2, sd2;
    logic [1:0] fi3, fi2;
    logic [15:0] rd3, ld3, rd2, ld2;
    bit go = 1'b0;
    int total = 0, bad = 0;

    always #5 clk_in = ~clk_in;

    frame_ring_buffer #(.WORD_SIZE(16), .DEPTH(DEPTH), .NUM_BUFS(3), .CLEAR_ON_SWAP(1'b1)) u_dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .swap_in(swap_in), .vsync_in(vsync_in),
        .render_addr_r(render_addr_r), .logic_addr_r(logic_addr_r), .logic_addr_w(logic_addr_w),
        .logic_data_w(logic_data_w), .logic_wr_en(logic_wr_en), .ready_out(ready3),
        .swap_done_out(sd3), .front_idx_out(fi3), .render_data_r(rd3), .logic_data_r(ld3));

    frame_ring_buffer #(.WORD_SIZE(16), .DEPTH(DEPTH), .NUM_BUFS(2), .CLEAR_ON_SWAP(1'b1)) u_dut2 (
        .clk_in(clk_in), .rst_in(rst_in), .swap_in(swap_in), .vsync_in(vsync_in),
        .render_addr_r(render_addr_r), .logic_addr_r(logic_addr_r), .logic_addr_w(logic_addr_w),
        .logic_data_w(logic_data_w), .logic_wr_en(logic_wr_en), .ready_out(ready2),
        .swap_done_out(sd2), .front_idx_out(fi2), .render_data_r(rd2), .logic_data_r(ld2));

    // Model: per instance (0 = three banks, 1 = two banks) bank contents plus role indices
    logic [15:0] mem [2][3][DEPTH];
    bit kn [2][3][DEPTH];
    int mode [2], left [2], back [2], front [2], disp [2];
    bit exp_sd [2], exp_lk [2], exp_rk [2];
    logic [15:0] exp_l [2], exp_r [2];

    task automatic m_reset(input int k);
        mode[k] = M_CLEAR;
        left[k] = DEPTH;
        back[k] = 1;
        front[k] = 0;
        disp[k] = 0;
        exp_sd[k] = 1'b0;
        exp_l[k] = '0;
        exp_r[k] = '0;
        exp_lk[k] = 1'b1;
        exp_rk[k] = 1'b1;
    endtask

    task automatic m_step(input int k);
        int nb, nd, old;
        bit rdy, rot;
        nb = k == 0 ? 3 : 2;
        rdy = mode[k] == M_READY;
        exp_l[k] = mem[k][front[k]][logic_addr_r];
        exp_lk[k] = kn[k][front[k]][logic_addr_r];
        exp_r[k] = mem[k][disp[k]][render_addr_r];
        exp_rk[k] = kn[k][disp[k]][render_addr_r];
        rot = (rdy && swap_in && nb == 3) || (mode[k] == M_WAIT && vsync_in);
        if (mode[k] == M_CLEAR) begin
            mem[k][back[k]][DEPTH - left[k]] = '0;
            kn[k][back[k]][DEPTH - left[k]] = 1'b1;
            left[k]--;
            if (left[k] == 0) mode[k] = M_READY;
        end else if (rdy && logic_wr_en) begin
            mem[k][back[k]][logic_addr_w] = logic_data_w;
            kn[k][back[k]][logic_addr_w] = 1'b1;
        end
        nd = (nb == 3 && vsync_in) ? front[k] : disp[k];
        exp_sd[k] = rot;
        if (rot) begin
            old = back[k];
            if (nb == 3) begin
                front[k] = old;
                for (int b = 0; b < 3; b++) if (b != old && b != nd) back[k] = b;
            end else begin
                back[k] = front[k];
                front[k] = old;
            end
            mode[k] = M_CLEAR;
            left[k] = DEPTH;
        end else if (rdy && swap_in && nb == 2) mode[k] = M_WAIT;
        disp[k] = nb == 2 ? front[k] : nd;
    endtask

    always @(posedge clk_in or posedge rst_in)
        for (int k = 0; k < 2; k++) if (rst_in) m_reset(k); else m_step(k);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) if (go) begin
        chk("ready3", 32'(ready3), 32'(mode[0] == M_READY && !rst_in));
        chk("swap_done3", 32'(sd3), 32'(exp_sd[0]));
        chk("front3", 32'(fi3), 32'(front[0]));
        if (exp_lk[0]) chk("logic_rd3", 32'(ld3), 32'(exp_l[0]));
        if (exp_rk[0]) chk("render_rd3", 32'(rd3), 32'(exp_r[0]));
        chk("ready2", 32'(ready2), 32'(mode[1] == M_READY && !rst_in));
        chk("swap_done2", 32'(sd2), 32'(exp_sd[1]));
        chk("front2", 32'(fi2), 32'(front[1]));
        if (exp_lk[1]) chk("logic_rd2", 32'(ld2), 32'(exp_l[1]));
        if (exp_rk[1]) chk("render_rd2", 32'(rd2), 32'(exp_r[1]));
    end

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_clear(input string nm);
        int n = 0;
        while (!ready3 && n < 100) begin
            cyc();
            n++;
        end
        chk(nm, 32'(n), 32'd16);
        chk({nm, "_ready2"}, 32'(ready2), 32'd1);
    endtask

    initial begin
        m_reset(0);
        m_reset(1);
        cyc();
        go = 1'b1;
        repeat (2) cyc();
        rst_in = 1'b0;
        wait_clear("clear_len");
        // Write to the back bank, then swap: triple buffer rotates at once, double buffer waits
        logic_wr_en = 1'b1; logic_addr_w = 4'd3; logic_data_w = 16'hA5A5;
        cyc();
        logic_wr_en = 1'b0; swap_in = 1'b1;
        cyc();
        chk("lit_sd3", 32'(sd3), 32'd1);
        chk("lit_front3", 32'(fi3), 32'd1);
        chk("lit_sd2_wait", 32'(sd2), 32'd0);
        chk("lit_ready2_wait", 32'(ready2), 32'd0);
        swap_in = 1'b0; logic_addr_r = 4'd3;
        cyc();
        chk("lit_ld3", 32'(ld3), 32'hA5A5);
        logic_wr_en = 1'b1; logic_addr_w = 4'd5; logic_data_w = 16'h1234;
        repeat (9) cyc();
        logic_wr_en = 1'b0; vsync_in = 1'b1;
        cyc();
        chk("lit_sd2", 32'(sd2), 32'd1);
        chk("lit_front2", 32'(fi2), 32'd1);
        vsync_in = 1'b0; logic_addr_r = 4'd5;
        cyc();
        chk("lit_ld2_ignored_wr", 32'(ld2), 32'd0);
        logic_addr_r = 4'd3;
        cyc();
        chk("lit_ld2", 32'(ld2), 32'hA5A5);
        // Swap during the double buffer's clear is dropped
        swap_in = 1'b1;
        cyc();
        swap_in = 1'b0;
        chk("lit_sd2_clear", 32'(sd2), 32'd0);
        chk("lit_front2_clear", 32'(fi2), 32'd1);
        begin
            int n = 0;
            while (!(ready3 && ready2) && n < 40) begin
                cyc();
                n++;
            end
            chk("ready_wait_bound", 32'(n < 40), 32'd1);
        end
        swap_in = 1'b1; vsync_in = 1'b1;
        cyc();
        swap_in = 1'b0; vsync_in = 1'b0;
        chk("lit_sv_sd3", 32'(sd3), 32'd1);
        chk("lit_sv_front3", 32'(fi3), 32'd2);
        chk("lit_sv_back3", 32'(u_dut3.back_idx), 32'd0);
        chk("lit_sv_disp3", 32'(u_dut3.disp_idx), 32'd1);
        chk("lit_sv_sd2", 32'(sd2), 32'd0);
        repeat (7) cyc();
        chk("lit_clr_cnt", 32'(u_dut3.clr_cnt), 32'd7);
        rst_in = 1'b1;
        #1;
        chk("rst_ready3", 32'(ready3), 32'd0);
        chk("rst_sd3", 32'(sd3), 32'd0);
        chk("rst_front3", 32'(fi3), 32'd0);
        chk("rst_ld3", 32'(ld3), 32'd0);
        chk("rst_rd3", 32'(rd3), 32'd0);
        chk("rst_front2", 32'(fi2), 32'd0);
        cyc();
        rst_in = 1'b0;
        wait_clear("reclear_len");
        repeat (3000) begin
            rst_in = $urandom_range(0, 999) == 0;
            swap_in = $urandom_range(0, 7) == 0;
            vsync_in = $urandom_range(0, 19) == 0;
            logic_wr_en = $urandom_range(0, 1) == 1;
            logic_addr_w = 4'($urandom_range(0, 15));
            logic_addr_r = 4'($urandom_range(0, 15));
            render_addr_r = 4'($urandom_range(0, 15));
            logic_data_w = 16'($urandom);
            cyc();
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_ring_buffer.md
# frame_ring_buffer

Parametrised successor to the two-bank frame double buffer: 2 or 3 frame banks rotated between render (display), logic-read (front) and logic-write (back) roles. Sits between the game-of-life logic engine and the VGA renderer. Adds:
- a frame-synchronised swap handshake;
- tear-free triple buffering;
- optional hardware clear of the new back bank.

## Interface
Parameters:
- WORD_SIZE, default 16: bits per word (matches data_t).
- DEPTH, default 4800: words per bank; LOG_DEPTH = $clog2(DEPTH).
- NUM_BUFS, default 3: bank count. Legal values 2 or 3; any other value fails elaboration.
- CLEAR_ON_SWAP, default 1: when 1, the new back bank is zeroed after every swap and after reset.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset. Asynchronous, active-high.
- swap_in  in  1  logic finished writing back bank; sampled only while ready_out=1.
- vsync_in  in  1  one-cycle pulse at the renderer frame boundary.
- render_addr_r  in  LOG_DEPTH  render read address.
- logic_addr_r  in  LOG_DEPTH  logic read address (front bank).
- logic_addr_w  in  LOG_DEPTH  logic write address (back bank).
- logic_data_w  in  WORD_SIZE  logic write data.
- logic_wr_en  in  1  write strobe.
- ready_out  out  1  back bank writable and swap_in accepted.
- swap_done_out  out  1  one-cycle pulse when roles rotate.
- front_idx_out  out  2  current front bank index.
- render_data_r  out  WORD_SIZE  render read data.
- logic_data_r  out  WORD_SIZE  logic read data.

## Operation
Role registers: back_idx, front_idx, disp_idx.
- Invariants: back_idx≠front_idx and back_idx≠disp_idx.
- NUM_BUFS=2: disp_idx≡front_idx.

FSM states: READY, WAIT_VSYNC, CLEAR.

READY:
- Logic writes go to back_idx.
- On swap_in, the next state depends on NUM_BUFS:
  - NUM_BUFS=2 → WAIT_VSYNC.
  - NUM_BUFS=3 → rotate immediately, pulse swap_done_out, then CLEAR (if CLEAR_ON_SWAP) else READY.

Rotation rules:
- NUM_BUFS=3: front_idx←back_idx; back_idx←the index not in {old back_idx, disp_idx after this cycle}.
- NUM_BUFS=2: swap front and back.

vsync_in:
- NUM_BUFS=3, any state: disp_idx←front_idx (value before any same-cycle rotation).
- NUM_BUFS=2, in WAIT_VSYNC: rotate, pulse swap_done_out, then CLEAR or READY.

CLEAR:
- Internal counter writes 0 to back bank addresses 0..DEPTH-1, one per cycle, then → READY.

ready_out and write/swap gating:
- ready_out=1 only in READY.
- logic_wr_en and swap_in are ignored outside READY.

Read paths:
- Read port A of each bank serves logic_addr_r; read port B serves render_addr_r.
- Output muxes select using the role index registered with the address, so a rotation between address and data never mixes banks.

## Timing
- Read latency: 1 cycle, address at edge N gives data after edge N+1, for both render and logic.
- Write takes effect at the edge where logic_wr_en=1. Read-during-write to the same bank cannot occur, by the invariants.
- swap_in→swap_done_out latency:
  - NUM_BUFS=3: 1 cycle.
  - NUM_BUFS=2: the edge after the first vsync_in seen in WAIT_VSYNC (not the edge sampling swap_in). swap_in and vsync_in in the same READY cycle still waits for the next vsync_in.
- CLEAR lasts exactly DEPTH cycles. ready_out rises the cycle after the last zero write.

Reset values (async):
- back_idx=1, front_idx=0, disp_idx=0.
- swap_done_out=0, front_idx_out=0.
- Read data registers 0.
- State = CLEAR if CLEAR_ON_SWAP, else READY; ready_out=0 while in reset.

Boundaries:
- Reset during CLEAR aborts the sweep; the clear restarts from address 0.
- Clear counter wraps only via the DEPTH-1 terminal compare, never by overflow.
- swap_in while ready_out=0 is dropped and not queued.

## Structure
- addr_t, data_t, LOG_MAX_ADDR and WORD_SIZE come from the common.svh package.
- Add buf_role_t (2-bit index) and the FSM state enum to the package.
- One sub-module, tdp_bank: an inferred true-dual-port RAM, DEPTH×WORD_SIZE, 1-cycle registered read. Instantiated NUM_BUFS times in a generate loop, replacing the per-bank IP cores.

## Test plan
- Reset, CLEAR_ON_SWAP=1, DEPTH=16 → ready_out=0 for 16 cycles after deassert, then 1; reads of bank 1 return 0.
- NUM_BUFS=3: write 0xA5A5 to back address 3, swap_in → swap_done_out at next edge, front_idx_out=1; logic read address 3 returns 0xA5A5 one cycle later; render still returns bank 0 data until vsync_in.
- NUM_BUFS=2: swap_in with vsync_in arriving 10 cycles later → ready_out=0 and writes ignored for those cycles; swap_done_out on the edge after vsync_in.
- NUM_BUFS=3, swap_in and vsync_in in the same cycle → disp_idx=old front, back_idx=the third bank, invariants hold.
- rst_in asserted mid-CLEAR at count 7 → outputs at reset values immediately; sweep restarts at address 0.
- swap_in during CLEAR → no swap_done_out, roles unchanged.
